prio_scan: RTL and testbench

//   Sequential, parametrised priority scanner: accepts one WIDTH-bit vector per transaction and

---
 rtl/prio_scan.sv | 150 +++++++++++++++
 tb/tb_prio_scan.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_scan.sv
// prio_scan: sequential priority scanner.
// Accepts one WIDTH-bit bitmap per transaction and streams out the index of
// every set bit, one index per output handshake, highest-first or lowest-first
// as selected per transaction. An all-zero bitmap yields a single "none" beat.
// Optional feature macro: PRIO_SCAN_COUNT_EN adds out_count, the popcount of
// the accepted bitmap, held for the whole transaction.
module prio_scan #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_lsb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_idx,
  output logic             out_last,
  output logic             out_none
`ifdef PRIO_SCAN_COUNT_EN
  ,
  output logic [8:0]       out_count
`endif
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;

  logic [7:0]       selIdx;
  logic [WIDTH-1:0] selMask;
  logic             remEmpty;
  logic             remSingle;

`ifdef PRIO_SCAN_COUNT_EN
  logic [8:0]       count_q, count_d;

  function automatic logic [8:0] popcount(input logic [WIDTH-1:0] v);
    logic [8:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + 9'(v[i]);
    end
    return cnt;
  endfunction
`endif

  // Pick the next bit to emit from the remaining bitmap: the last match in the
  // loop wins, so scanning upward finds the highest bit and downward the lowest.
  always_comb begin
    selIdx  = '0;
    selMask = '0;
    if (mode_q) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (rem_q[i]) begin
          selIdx     = 8'(i);
          selMask    = '0;
          selMask[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (rem_q[i]) begin
          selIdx     = 8'(i);
          selMask    = '0;
          selMask[i] = 1'b1;
        end
      end
    end
  end

  // Beat classification: the current beat is the last when at most one bit
  // remains; an empty bitmap in SCAN can only come from a zero vector.
  always_comb begin
    remEmpty  = (rem_q == '0);
    remSingle = ((rem_q & (rem_q - WIDTH'(1))) == '0);
  end

  // Next-state logic: accept in IDLE, clear one bit per handshake in SCAN and
  // return to IDLE after the last beat (in_ready only rises the cycle after).
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
`ifdef PRIO_SCAN_COUNT_EN
    count_d = count_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = in_vec;
          mode_d  = in_lsb_first;
          state_d = SCAN;
`ifdef PRIO_SCAN_COUNT_EN
          count_d = popcount(in_vec);
`endif
        end
      end
      SCAN: begin
        if (out_ready) begin
          rem_d = rem_q & ~selMask;
          if (remSingle) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from registered state only, so they stay stable while
  // the consumer holds off out_ready.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == SCAN);
    out_idx   = (state_q == SCAN) ? selIdx : 8'd0;
    out_last  = (state_q == SCAN) && remSingle;
    out_none  = (state_q == SCAN) && remEmpty;
`ifdef PRIO_SCAN_COUNT_EN
    out_count = count_q;
`endif
  end

  // State registers with synchronous active-low reset; reset drops any
  // transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      mode_q  <= 1'b0;
`ifdef PRIO_SCAN_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
`ifdef PRIO_SCAN_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

endmodule

// File: tb/tb_prio_scan.sv
// tb_prio_scan: self-checking bench for prio_scan.
// Two instances share clock and reset: a 16-bit one for the directed and
// randomized scenarios and a 256-bit one for the wide-index case.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_prio_scan;

  localparam int W  = 16;
  localparam int WW = 256;

  logic clk = 1'b0;
  logic rst_n;

  logic          inValid, inReady, inLsbFirst, outValid, outReady;
  logic [W-1:0]  inVec;
  logic [7:0]    outIdx;
  logic          outLast, outNone;

  logic          wInValid, wInReady, wInLsbFirst, wOutValid, wOutReady;
  logic [WW-1:0] wInVec;
  logic [7:0]    wOutIdx;
  logic          wOutLast, wOutNone;

`ifdef PRIO_SCAN_COUNT_EN
  logic [8:0]    outCount, wOutCount;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int expQ[$];

  always #5 clk = ~clk;

  prio_scan #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid), .in_ready(inReady), .in_vec(inVec), .in_lsb_first(inLsbFirst),
    .out_valid(outValid), .out_ready(outReady), .out_idx(outIdx),
    .out_last(outLast), .out_none(outNone)
`ifdef PRIO_SCAN_COUNT_EN
    , .out_count(outCount)
`endif
  );

  prio_scan #(.WIDTH(WW)) dutWide (
    .clk(clk), .rst_n(rst_n),
    .in_valid(wInValid), .in_ready(wInReady), .in_vec(wInVec), .in_lsb_first(wInLsbFirst),
    .out_valid(wOutValid), .out_ready(wOutReady), .out_idx(wOutIdx),
    .out_last(wOutLast), .out_none(wOutNone)
`ifdef PRIO_SCAN_COUNT_EN
    , .out_count(wOutCount)
`endif
  );

  // Reference model: the list of set-bit indices in emission order.
  task automatic modelScan(input logic [255:0] v, input int width, input logic lsb);
    expQ.delete();
    for (int i = 0; i < width; i++) begin
      if (v[i]) begin
        if (lsb) expQ.push_back(i);
        else     expQ.push_front(i);
      end
    end
  endtask

  // Present one vector to the 16-bit instance for a single accepting cycle.
  task automatic applyStimulus(input logic [W-1:0] vec, input logic lsb);
    @(negedge clk);
    inVec      = vec;
    inLsbFirst = lsb;
    inValid    = 1'b1;
    @(negedge clk);
    inValid    = 1'b0;
    inVec      = W'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0; inVec = '0; inLsbFirst = 1'b0;
    wInValid = 1'b0; wOutReady = 1'b0; wInVec = '0; wInLsbFirst = 1'b0;
    @(negedge clk);
    testsRun++; if (inReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset in_ready got %0b want 1", inReady); end
    testsRun++; if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset out_valid got %0b want 0", outValid); end
    testsRun++; if (outIdx !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset out_idx got %0d want 0", outIdx); end
    testsRun++; if (outLast !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset out_last got %0b want 0", outLast); end
    testsRun++; if (outNone !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset out_none got %0b want 0", outNone); end
    testsRun++; if (wInReady !== 1'b1 || wOutValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset wide ready/valid got %0b/%0b want 1/0", wInReady, wOutValid); end
    rst_n = 1'b1;
  endtask

  task automatic test_msb_first();
    int expIdx[4] = '{15, 10, 5, 0};
    outReady = 1'b1;
    applyStimulus(16'h8421, 1'b0);
    for (int k = 0; k < 4; k++) begin
      testsRun++; if (outValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL msb valid beat %0d got %0b want 1", k, outValid); end
      testsRun++; if (outIdx !== 8'(expIdx[k])) begin testsFailed++; $display("[TB] FAIL msb idx beat %0d got %0d want %0d", k, outIdx, expIdx[k]); end
      testsRun++; if (outLast !== (k == 3)) begin testsFailed++; $display("[TB] FAIL msb last beat %0d got %0b want %0b", k, outLast, k == 3); end
      testsRun++; if (inReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL msb in_ready beat %0d got %0b want 0", k, inReady); end
      @(negedge clk);
    end
    testsRun++; if (inReady !== 1'b1 || outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL msb after ready/valid got %0b/%0b want 1/0", inReady, outValid); end
    outReady = 1'b0;
  endtask

  task automatic test_backpressure();
    int expIdx[4] = '{0, 5, 10, 15};
    int k = 0;
    outReady = 1'b0;
    applyStimulus(16'h8421, 1'b1);
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      testsRun++; if (outValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp valid cyc %0d got %0b want 1", cyc, outValid); end
      testsRun++; if (outIdx !== 8'(expIdx[k])) begin testsFailed++; $display("[TB] FAIL bp idx cyc %0d got %0d want %0d", cyc, outIdx, expIdx[k]); end
      testsRun++; if (outLast !== (k == 3)) begin testsFailed++; $display("[TB] FAIL bp last cyc %0d got %0b want %0b", cyc, outLast, k == 3); end
      outReady = cyc[0];
      if (outReady) k++;
      @(negedge clk);
    end
    outReady = 1'b0;
    testsRun++; if (k != 4) begin testsFailed++; $display("[TB] FAIL bp beats got %0d want 4", k); end
    testsRun++; if (inReady !== 1'b1 || outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp after ready/valid got %0b/%0b want 1/0", inReady, outValid); end
  endtask

  task automatic test_zero_vector();
    outReady = 1'b1;
    applyStimulus(16'h0000, 1'b0);
    testsRun++; if (outValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL zero valid got %0b want 1", outValid); end
    testsRun++; if (outIdx !== 8'd0) begin testsFailed++; $display("[TB] FAIL zero idx got %0d want 0", outIdx); end
    testsRun++; if (outNone !== 1'b1) begin testsFailed++; $display("[TB] FAIL zero none got %0b want 1", outNone); end
    testsRun++; if (outLast !== 1'b1) begin testsFailed++; $display("[TB] FAIL zero last got %0b want 1", outLast); end
`ifdef PRIO_SCAN_COUNT_EN
    testsRun++; if (outCount !== 9'd0) begin testsFailed++; $display("[TB] FAIL zero count got %0d want 0", outCount); end
`endif
    @(negedge clk);
    testsRun++; if (inReady !== 1'b1 || outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero after ready/valid got %0b/%0b want 1/0", inReady, outValid); end
    outReady = 1'b0;
  endtask

  task automatic test_reset_mid();
    outReady = 1'b1;
    applyStimulus(16'hFFFF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      testsRun++; if (outIdx !== 8'(15 - k)) begin testsFailed++; $display("[TB] FAIL rstmid idx beat %0d got %0d want %0d", k, outIdx, 15 - k); end
      @(negedge clk);
    end
    rst_n = 1'b0; outReady = 1'b0;
    @(negedge clk);
    testsRun++; if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid valid got %0b want 0", outValid); end
    testsRun++; if (inReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid in_ready got %0b want 1", inReady); end
    testsRun++; if (outIdx !== 8'd0 || outLast !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid idx/last got %0d/%0b want 0/0", outIdx, outLast); end
    rst_n = 1'b1; outReady = 1'b1;
    applyStimulus(16'h0002, 1'b0);
    testsRun++; if (outValid !== 1'b1 || outIdx !== 8'd1) begin testsFailed++; $display("[TB] FAIL rstmid next valid/idx got %0b/%0d want 1/1", outValid, outIdx); end
    testsRun++; if (outLast !== 1'b1 || outNone !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid next last/none got %0b/%0b want 1/0", outLast, outNone); end
    @(negedge clk);
    testsRun++; if (outValid !== 1'b0 || inReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid end valid/ready got %0b/%0b want 0/1", outValid, inReady); end
    outReady = 1'b0;
  endtask

  // Random vectors, random order, random backpressure; in_valid stays high with
  // junk data during the scan and must be ignored.
  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] vec;
      logic         lsb, noneCase, done;
      int           expCount;
      case ($urandom % 4)
        0:       vec = '0;
        1:       vec = W'(1) << ($urandom % W);
        default: vec = W'($urandom);
      endcase
      lsb = 1'($urandom);
      modelScan(256'(vec), W, lsb);
      noneCase = (expQ.size() == 0);
      expCount = expQ.size();
      done     = 1'b0;
      @(negedge clk);
      inVec = vec; inLsbFirst = lsb; inValid = 1'b1; outReady = 1'($urandom);
      @(negedge clk);
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
        inVec = W'($urandom); inLsbFirst = 1'($urandom);
        testsRun++; if (outValid !== 1'b1 || inReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL rand valid/ready t%0d got %0b/%0b want 1/0", t, outValid, inReady); end
        testsRun++; if (outIdx !== (noneCase ? 8'd0 : 8'(expQ[0]))) begin testsFailed++; $display("[TB] FAIL rand idx t%0d vec %h got %0d want %0d", t, vec, outIdx, noneCase ? 0 : expQ[0]); end
        testsRun++; if (outLast !== (expQ.size() <= 1)) begin testsFailed++; $display("[TB] FAIL rand last t%0d got %0b want %0b", t, outLast, expQ.size() <= 1); end
        testsRun++; if (outNone !== noneCase) begin testsFailed++; $display("[TB] FAIL rand none t%0d got %0b want %0b", t, outNone, noneCase); end
`ifdef PRIO_SCAN_COUNT_EN
        testsRun++; if (outCount !== 9'(expCount)) begin testsFailed++; $display("[TB] FAIL rand count t%0d got %0d want %0d", t, outCount, expCount); end
`endif
        outReady = 1'($urandom);
        if (outReady) begin
          if (expQ.size() > 0) void'(expQ.pop_front());
          if (expQ.size() == 0) begin
            done    = 1'b1;
            inValid = 1'b0;
          end
        end
        @(negedge clk);
      end
      inValid = 1'b0; outReady = 1'b0;
      testsRun++; if (!done) begin testsFailed++; $display("[TB] FAIL rand timeout t%0d beats left %0d want 0", t, expQ.size()); end
      testsRun++; if (inReady !== 1'b1 || outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rand end t%0d ready/valid got %0b/%0b want 1/0", t, inReady, outValid); end
    end
  endtask

  // 256-bit instance: top index 255 must fit the 8-bit index without wrap.
  task automatic test_wide();
    for (int t = 0; t < 2; t++) begin
      logic [WW-1:0] vec;
      logic          lsb;
      int            expCount;
      int            cyc;
      if (t == 0) begin
        vec = '0; vec[255] = 1'b1; vec[128] = 1'b1; vec[1] = 1'b1; lsb = 1'b0;
      end else begin
        vec = {8{$urandom}}; vec[0] = 1'b1; vec[255] = 1'b1; lsb = 1'b1;
      end
      modelScan(vec, WW, lsb);
      expCount = expQ.size();
      wOutReady = 1'b1;
      @(negedge clk);
      wInVec = vec; wInLsbFirst = lsb; wInValid = 1'b1;
      @(negedge clk);
      wInValid = 1'b0;
      cyc = 0;
      while (expQ.size() > 0 && cyc < 300) begin
        testsRun++; if (wOutValid !== 1'b1 || wOutIdx !== 8'(expQ[0])) begin testsFailed++; $display("[TB] FAIL wide t%0d valid/idx got %0b/%0d want 1/%0d", t, wOutValid, wOutIdx, expQ[0]); end
        testsRun++; if (wOutLast !== (expQ.size() == 1)) begin testsFailed++; $display("[TB] FAIL wide t%0d last got %0b want %0b", t, wOutLast, expQ.size() == 1); end
`ifdef PRIO_SCAN_COUNT_EN
        testsRun++; if (wOutCount !== 9'(expCount)) begin testsFailed++; $display("[TB] FAIL wide t%0d count got %0d want %0d", t, wOutCount, expCount); end
`endif
        void'(expQ.pop_front());
        cyc++;
        @(negedge clk);
      end
      testsRun++; if (wOutValid !== 1'b0 || wInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL wide t%0d end valid/ready got %0b/%0b want 0/1 (count %0d)", t, wOutValid, wInReady, expCount); end
      wOutReady = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_backpressure();
    test_zero_vector();
    test_reset_mid();
    test_random();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
